// File: rtl/spi_master_ctrl_if.sv
// Command/response channel of spi_master_ctrl: words to shift out, words shifted in.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_last;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_last,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_last,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: all four modes, programmable SCLK divider, DATA_W-bit words, NUM_SS
// active-low selects; multi-word frames keep SS asserted between words.
module spi_master_ctrl #(
  parameter  int DATA_W = 8,
  parameter  int NUM_SS = 1,
  parameter  int DIV_W  = 8,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpol,
  input  logic               cpha,
  input  logic [DIV_W-1:0]   clk_div,
  input  logic [SEL_W-1:0]   ss_sel,
  spi_master_ctrl_if.slave   cmd_if,
  output logic               busy,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO,
  output logic [NUM_SS-1:0]  SS
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_HOLD,
    S_STOP,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                cpha_q, cpha_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic [NUM_SS-1:0]   ss_q, ss_d;
  logic                rsp_pend_q, rsp_pend_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic                tick;
  logic                accept;
  logic                load_en;
  logic                load_cpha;
  logic [NUM_SS-1:0]   ss_decode;

  assign cmd_if.cmd_ready = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign accept           = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign tick             = (cnt_q == div_q);

  assign busy             = (state_q != S_IDLE);
  assign SCLK             = sclk_q;
  assign MOSI             = mosi_q;
  assign SS               = ss_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;

  // An out-of-range index matches no line, so the frame runs with every select high.
  always_comb begin
    for (int i = 0; i < NUM_SS; i++) begin
      ss_decode[i] = (ss_sel != SEL_W'(i));
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    div_d       = div_q;
    edge_d      = edge_q;
    cpha_d      = cpha_q;
    last_d      = last_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    mosi_d      = mosi_q;
    sclk_d      = sclk_q;
    ss_d        = ss_q;
    rsp_pend_d  = 1'b0;
    rsp_valid_d = rsp_pend_q;
    rsp_data_d  = rsp_pend_q ? rx_q : rsp_data_q;
    load_en     = 1'b0;
    load_cpha   = cpha_q;
    cnt_d       = tick ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        sclk_d = cpol;
        if (accept) begin
          cpha_d    = cpha;
          div_d     = clk_div;
          last_d    = cmd_if.cmd_last;
          ss_d      = ss_decode;
          load_en   = 1'b1;
          load_cpha = cpha;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          edge_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          // Even edges are leading; sample on the edge whose parity matches CPHA, shift on the other.
          if (edge_q[0] == cpha_q) begin
            rx_d = {rx_q[DATA_W-2:0], MISO};
          end else begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          edge_d = edge_q + EDGE_W'(1);
          if (edge_q == LAST_EDGE) begin
            edge_d     = '0;
            rsp_pend_d = 1'b1;
            state_d    = last_q ? S_STOP : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (accept) begin
          last_d  = cmd_if.cmd_last;
          load_en = 1'b1;
          edge_d  = '0;
          state_d = S_XFER;
        end
      end
      S_STOP: begin
        if (tick) begin
          ss_d    = '1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ss_d    = '1;
      end
    endcase

    // With CPHA=0 the MSB must be on MOSI before the first (sampling) edge.
    if (load_en) begin
      if (!load_cpha) begin
        mosi_d = cmd_if.cmd_data[DATA_W-1];
        tx_d   = cmd_if.cmd_data << 1;
      end else begin
        tx_d   = cmd_if.cmd_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      edge_q      <= '0;
      cpha_q      <= 1'b0;
      last_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      ss_q        <= '1;
      rsp_pend_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      edge_q      <= edge_d;
      cpha_q      <= cpha_d;
      last_q      <= last_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: modes 0/1/3, divider, multi-word frames,
// slave-select decode, mid-frame reset and command backpressure.
module tb_spi_master_ctrl;

  localparam int DATA_W = 8;
  localparam int NUM_SS = 5;
  localparam int DIV_W  = 8;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic [SEL_W-1:0]  ss_sel = '0;
  logic              busy;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic [NUM_SS-1:0] SS;

  logic loop_en  = 1'b1;
  logic miso_val = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_master_ctrl_if #(.DATA_W(DATA_W)) bus ();

  assign MISO = loop_en ? MOSI : miso_val;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .DATA_W (DATA_W),
    .NUM_SS (NUM_SS),
    .DIV_W  (DIV_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpol    (cpol),
    .cpha    (cpha),
    .clk_div (clk_div),
    .ss_sel  (ss_sel),
    .cmd_if  (bus.slave),
    .busy    (busy),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .SS      (SS)
  );

  // Passive monitors; the directed sequence works on deltas of these.
  int         sclk_rise = 0;
  logic [7:0] mosi_bits = '0;
  time        rise_t0 = 0;
  time        rise_t1 = 0;
  int         rsp_cnt = 0;
  int         ss0_low = 0;
  int         ss0_rise = 0;
  time        acc_t0 = 0;
  time        acc_t1 = 0;

  always @(posedge SCLK) begin
    sclk_rise = sclk_rise + 1;
    mosi_bits = {mosi_bits[6:0], MOSI};
    rise_t0   = rise_t1;
    rise_t1   = $time;
  end

  always @(posedge SS[0]) ss0_rise = ss0_rise + 1;

  always @(negedge clk) begin
    if (bus.rsp_valid) rsp_cnt = rsp_cnt + 1;
    if (!SS[0]) ss0_low = ss0_low + 1;
  end

  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_t0 = acc_t1;
      acc_t1 = $time;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_last  = last;
    while (!bus.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [7:0] d, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.rsp_valid && lat < 2000);
    check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    d = bus.rsp_data;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    int lat;
    int base_rise, base_low, base_rsp, base_ssr, n, bad;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_last  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ss", 32'(SS), 32'h1F);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);

    // Mode 0, clk_div=0, loopback, 0xA5
    base_rise = sclk_rise;
    base_low  = ss0_low;
    send(8'hA5, 1'b1);
    wait_rsp(r, lat);
    check("m0_rsp", 32'(r), 32'hA5);
    check("m0_latency", 32'(lat), 32'd18);
    wait_idle();
    check("m0_rises", 32'(sclk_rise - base_rise), 32'd8);
    check("m0_ss_low_cycles", 32'(ss0_low - base_low), 32'd18);
    check("m0_mosi_bits", 32'(mosi_bits), 32'hA5);
    check("m0_ss_idle", 32'(SS), 32'h1F);

    // Mode 3, clk_div=3, MISO tied high, 0x3C
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b1; clk_div = 8'd3; loop_en = 1'b0; miso_val = 1'b1;
    repeat (3) @(negedge clk);
    check("m3_sclk_idle", 32'(SCLK), 32'd1);
    base_rise = sclk_rise;
    send(8'h3C, 1'b1);
    wait_rsp(r, lat);
    check("m3_rsp", 32'(r), 32'hFF);
    wait_idle();
    check("m3_rises", 32'(sclk_rise - base_rise), 32'd8);
    check("m3_mosi_bits", 32'(mosi_bits), 32'h3C);
    check("m3_period", 32'(rise_t1 - rise_t0), 32'd80);
    check("m3_sclk_after", 32'(SCLK), 32'd1);

    // Mode 1, two-word frame; cfg inputs changed during HOLD must be ignored
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b1; clk_div = 8'd1; loop_en = 1'b1;
    repeat (3) @(negedge clk);
    base_ssr = ss0_rise;
    base_rsp = rsp_cnt;
    send(8'h12, 1'b0);
    wait_rsp(r, lat);
    check("m1_rsp0", 32'(r), 32'h12);
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; clk_div = 8'd0;
    repeat (3) @(negedge clk);
    check("m1_hold_sclk", 32'(SCLK), 32'd0);
    check("m1_hold_busy", 32'(busy), 32'd1);
    check("m1_hold_ready", 32'(bus.cmd_ready), 32'd1);
    check("m1_hold_ss", 32'(SS[0]), 32'd0);
    send(8'h34, 1'b1);
    wait_rsp(r, lat);
    check("m1_rsp1", 32'(r), 32'h34);
    wait_idle();
    check("m1_ss_rises", 32'(ss0_rise - base_ssr), 32'd1);
    check("m1_rsp_pulses", 32'(rsp_cnt - base_rsp), 32'd2);

    // Slave-select decode
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; ss_sel = 3'd2;
    repeat (2) @(negedge clk);
    send(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    check("sel2_ss", 32'(SS), 32'h1B);
    wait_rsp(r, lat);
    check("sel2_rsp", 32'(r), 32'hC3);
    wait_idle();
    ss_sel   = 3'd5;
    base_rsp = rsp_cnt;
    send(8'h96, 1'b1);
    repeat (4) @(negedge clk);
    check("sel5_ss", 32'(SS), 32'h1F);
    check("sel5_busy", 32'(busy), 32'd1);
    wait_rsp(r, lat);
    check("sel5_rsp", 32'(r), 32'h96);
    wait_idle();
    check("sel5_pulses", 32'(rsp_cnt - base_rsp), 32'd1);

    // Reset in the middle of a transfer
    ss_sel    = 3'd0;
    base_rise = sclk_rise;
    base_rsp  = rsp_cnt;
    send(8'hF0, 1'b1);
    n = 0;
    while ((sclk_rise - base_rise) < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached", 32'(sclk_rise - base_rise), 32'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ss", 32'(SS), 32'h1F);
    check("rst_mid_sclk", 32'(SCLK), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_mid_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
    send(8'h5A, 1'b1);
    wait_rsp(r, lat);
    check("rst_recover_rsp", 32'(r), 32'h5A);
    check("rst_recover_lat", 32'(lat), 32'd18);
    wait_idle();

    // cmd_valid held high: next word only after the frame returns to IDLE
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 8'h11;
    bus.cmd_last  = 1'b1;
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (busy && bus.cmd_ready) bad++;
    end
    bus.cmd_valid = 1'b0;
    check("held_ready_busy", 32'(bad), 32'd0);
    check("held_accept_gap", 32'(acc_t1 - acc_t0), 32'd200);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
